// File: rtl/stage_pre_if.sv
// Pre-IF fetch stage: owns the fetch PC, issues one SRAM-style request at a time and buffers the word for IF.
// Optional misaligned-fetch trap enabled by defining PREIF_ADEF_CHECK_EN.
module stage_pre_if #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        allowout,
  output logic        validout,
  output logic [31:0] output_pc,
  output logic [31:0] output_inst,
  output logic        output_adef,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic        buf_adef, buf_adef_nxt;
  logic        discard, discard_nxt;
  logic        addr_err;

`ifdef PREIF_ADEF_CHECK_EN
  assign addr_err       = (req_addr[1:0] != 2'b00);
  assign inst_sram_addr = req_addr;
`else
  assign addr_err       = 1'b0;
  assign inst_sram_addr = {req_addr[31:2], 2'b00};
`endif

  assign inst_sram_req = (state == REQ) && !addr_err;
  assign validout      = (state == HOLD);
  assign output_pc     = buf_pc;
  assign output_inst   = buf_inst;
  assign output_adef   = buf_adef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
      buf_pc   <= '0;
      buf_inst <= '0;
      buf_adef <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      discard  <= discard_nxt;
      buf_pc   <= buf_pc_nxt;
      buf_inst <= buf_inst_nxt;
      buf_adef <= buf_adef_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    discard_nxt  = discard;
    buf_pc_nxt   = buf_pc;
    buf_inst_nxt = buf_inst;
    buf_adef_nxt = buf_adef;
    case (state)
      IDLE: begin
        state_nxt    = REQ;
        req_addr_nxt = pc;
      end
      REQ: begin
        if (addr_err) begin
          // A trapped fetch completes locally in one cycle, so a redirect behaves like a dropped return.
          if (redirect_valid) begin
            req_addr_nxt = redirect_pc;
            discard_nxt  = 1'b0;
          end else if (discard) begin
            req_addr_nxt = pc;
            discard_nxt  = 1'b0;
          end else begin
            state_nxt    = HOLD;
            buf_pc_nxt   = req_addr;
            buf_inst_nxt = 32'h0;
            buf_adef_nxt = 1'b1;
          end
        end else begin
          if (inst_sram_addr_ok) state_nxt = WAIT;
          if (redirect_valid)    discard_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (inst_sram_data_ok) begin
          if (redirect_valid) begin
            state_nxt    = REQ;
            req_addr_nxt = redirect_pc;
            discard_nxt  = 1'b0;
          end else if (discard) begin
            state_nxt    = REQ;
            req_addr_nxt = pc;
            discard_nxt  = 1'b0;
          end else begin
            state_nxt    = HOLD;
            buf_pc_nxt   = req_addr;
            buf_inst_nxt = inst_sram_rdata;
            buf_adef_nxt = 1'b0;
          end
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_nxt    = REQ;
          req_addr_nxt = redirect_pc;
        end else if (allowout) begin
          state_nxt    = REQ;
          pc_nxt       = pc + 32'd4;
          req_addr_nxt = pc + 32'd4;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) pc_nxt = redirect_pc;
  end

endmodule

// File: doc/stage_pre_if.md
# stage_pre_if

Pre-IF fetch stage: holds the architectural fetch PC, issues one instruction request at a time on a req/addr_ok/data_ok SRAM-like interface, and buffers the returned word until the IF stage accepts it. It sits directly upstream of `stage_if` and drives its `validin`/`input_pc`/instruction inputs. Branch/exception redirects from later stages retarget the PC and squash any request already in flight.

## Interface
- `RESET_PC`, 32'h1c000000, first fetch address after reset
- `clk`  in  1  clock, all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `allowout`  in  1  IF stage `allowin`
- `validout`  out  1  buffered instruction valid to IF
- `output_pc`  out  32  PC of buffered instruction
- `output_inst`  out  32  buffered instruction word
- `output_adef`  out  1  fetch-address-error flag (see Configuration)
- `redirect_valid`  in  1  single-cycle redirect request
- `redirect_pc`  in  32  redirect target
- `inst_sram_req`  out  1  request valid
- `inst_sram_addr`  out  32  request address
- `inst_sram_addr_ok`  in  1  request accepted this cycle
- `inst_sram_data_ok`  in  1  read data returned this cycle
- `inst_sram_rdata`  in  32  read data

## Operation
- Registers: `pc` (next fetch PC), `req_addr`, `discard`, buffer {`buf_pc`, `buf_inst`, `buf_adef`}, `state`.
- States: IDLE, REQ, WAIT, HOLD. Max one outstanding request.
- IDLE → REQ unconditionally; entering REQ latches `req_addr <= pc`.
- REQ: `inst_sram_req=1`, `inst_sram_addr=req_addr`, both stable until `addr_ok`. `addr_ok` → WAIT.
- WAIT: `data_ok` with `discard=0` → HOLD, buffer ← {`req_addr`, `rdata`}; with `discard=1` → REQ (new `req_addr <= pc`), clear `discard`, data dropped.
- HOLD: `validout=1`. Fire (`validout && allowout`) → `pc <= pc + 4` (32-bit wrap), → REQ.
- Redirect (priority over all sequential updates): `pc <= redirect_pc`.
  - IDLE: no other effect.
  - REQ or WAIT: set `discard`; the pending/outstanding request completes on the bus and its data is dropped.
  - HOLD: buffer invalidated, → REQ with `req_addr <= redirect_pc`. If fire occurs in the same cycle, the transfer still completes (IF cancels it); PC takes `redirect_pc`, not `pc+4`.
  - WAIT with `data_ok` in the same cycle: data dropped, → REQ with `req_addr <= redirect_pc`, `discard` cleared.
  - REQ with `addr_ok` in the same cycle: → WAIT with `discard=1`.
- Second redirect while `discard=1`: only `pc` updates; single drop still pending.

## Timing
- Reset values: `state=IDLE`, `pc=RESET_PC`, `discard=0`, `validout=0`, `inst_sram_req=0`, `inst_sram_addr=RESET_PC`, `output_pc=0`, `output_inst=0`, `output_adef=0`.
- `inst_sram_req` and `validout` are decoded from registered state only; no combinational path from any input.
- `data_ok` is ignored outside WAIT; slave returns `data_ok` ≥1 cycle after `addr_ok`.
- Minimum latency, zero-wait slave: reset release → req (cycle 1) → addr_ok (cycle 1) → data_ok (cycle 2) → `validout` (cycle 3). Steady state: one instruction per 3 cycles.
- `rst_n` asserted mid-transaction: immediate return to reset values; slave is reset by the same signal.

## Configuration
- `PREIF_ADEF_CHECK_EN` defined: a REQ entered with `req_addr[1:0]!=0` issues no bus request; the next cycle goes to HOLD with `buf_inst=32'h0`, `buf_adef=1`, `buf_pc=req_addr`. Redirect/discard rules are unchanged.
- Undefined: `output_adef` tied 0; `inst_sram_addr` = {`req_addr[31:2]`, 2'b00}.

## Test plan
- Reset release, `addr_ok=1`, `data_ok` 1 cycle later with `rdata=32'h02800c0c` → `validout` at cycle 3, `output_pc=32'h1c000000`; `allowout=1` → next `inst_sram_addr=32'h1c000004`.
- `allowout=0` for 5 cycles in HOLD → `validout`, `output_pc`, and `output_inst` stable; `inst_sram_req=0`.
- Redirect to `32'h1c000100` in WAIT, `data_ok` 2 cycles later → no `validout`; next request addr `32'h1c000100`.
- Redirect in REQ while `addr_ok=0` for 3 cycles → `inst_sram_addr` is held at the old PC until `addr_ok`, its data is dropped, and the following request uses the redirect target.
- Redirect and fire in the same HOLD cycle → one transfer; next `inst_sram_addr=redirect_pc`.
- With `PREIF_ADEF_CHECK_EN`, redirect to `32'h1c000102` → no `inst_sram_req`; `validout` with `output_adef=1`, `output_pc=32'h1c000102`.
